// File: rtl/apb3_request_sequencer_pkg.sv
// Shared types for the APB3 request sequencer: FSM state encoding,
// the queued request record and small sizing helpers.
package apb3_request_sequencer_pkg;

  // Request fields are stored at their widest legal size. Narrower instances
  // zero-extend on the way into the queue and slice on the way out.
  localparam int unsigned MaxAddrWidth = 32;
  localparam int unsigned MaxDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] wdata;
  } req_t;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int unsigned wait_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/apb3_request_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending requests.
// full/empty come straight from registers so the producer-side ready
// never depends on the same-cycle pop.
module apb3_request_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrWidth   = $clog2(Depth);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [Width-1:0]      r_mem [Depth];
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [CountWidth-1:0] r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_do_push;
  logic                  w_do_pop;

  // A full queue refuses a push even while it is being popped.
  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  // Storage write port; the head is read combinationally below.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer, occupancy and flag bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10: begin
          r_count <= r_count + 1'b1;
          r_full  <= (r_count == CountWidth'(Depth - 1));
          r_empty <= 1'b0;
        end
        2'b01: begin
          r_count <= r_count - 1'b1;
          r_full  <= 1'b0;
          r_empty <= (r_count == CountWidth'(1));
        end
        default: begin
          // push+pop together or idle: occupancy unchanged
        end
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/apb3_request_sequencer.sv
// Queues simple read/write requests and replays them one at a time as APB3
// manager transfers, returning one response per request in order.
// AddressWidth must not exceed 32.
module apb3_request_sequencer
  import apb3_request_sequencer_pkg::*;
#(
  parameter int unsigned AddressWidth  = 20,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic                    pready,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pslverr
);

  localparam int unsigned          WaitWidth = wait_width(TimeoutCycles);
  localparam logic [WaitWidth-1:0] WaitLast  = WaitWidth'(TimeoutCycles - 1);

  req_t                    w_push_req;
  req_t                    w_head_req;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_unused_head;

  state_t                  r_state;
  logic [WaitWidth-1:0]    r_wait;
  logic [AddressWidth-1:0] r_paddr;
  logic                    r_pwrite;
  logic [DataWidth-1:0]    r_pwdata;
  logic                    r_pselx;
  logic                    r_penable;
  logic                    r_rsp_valid;
  logic [DataWidth-1:0]    r_rsp_rdata;
  logic                    r_rsp_error;

  // Ready is held low while reset is asserted; otherwise it is the registered not-full flag.
  assign req_ready = !w_full && !rst;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == IDLE) && !w_empty;

  // Widen the incoming request into the queue record.
  always_comb begin
    w_push_req       = '0;
    w_push_req.write = req_write;
    w_push_req.addr  = MaxAddrWidth'(req_addr);
    w_push_req.wdata = MaxDataWidth'(req_wdata);
  end

  // Padding bits above the configured widths are always zero and never read.
  assign w_unused_head = ^w_head_req;

  apb3_request_fifo #(
    .Depth (FifoDepth),
    .Width ($bits(req_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_req),
    .i_pop       (w_pop),
    .o_data      (w_head_req),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Transfer sequencer: IDLE pops, SETUP/ACCESS run the APB phases, RESP holds the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pselx     <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_paddr  <= w_head_req.addr[AddressWidth-1:0];
            r_pwrite <= w_head_req.write;
            r_pwdata <= w_head_req.wdata[DataWidth-1:0];
            r_pselx  <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_error <= pslverr;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if ((TimeoutCycles != 0) && (r_wait == WaitLast)) begin
            // Completer never answered: give up and report an error.
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b1;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_apb3_request_sequencer.sv
// Bench for apb3_request_sequencer: directed scenarios with literal
// expectations, a scripted APB completer, and a transaction-level model
// compared against every output on every cycle after reset.
`timescale 1ns/1ps
module tb_apb3_request_sequencer;

  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] paddr;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready  = 1'b0;
  logic [DW-1:0] prdata  = '0;
  logic          pslverr = 1'b0;

  always #5 clk = ~clk;

  apb3_request_sequencer #(
    .AddressWidth  (AW),
    .DataWidth     (DW),
    .FifoDepth     (DEPTH),
    .TimeoutCycles (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- scripted APB completer ----------------
  int            slv_delay   = 0;   // ACCESS cycles with pready low before answering
  bit            slv_err     = 0;   // pslverr driven with pready=1
  bit            slv_err_low = 0;   // pslverr driven while pready=0 (must be ignored)
  bit            slv_fixed   = 1;   // 1: answer slv_rdata, 0: answer {A5A, paddr}
  logic [DW-1:0] slv_rdata   = '0;
  int            acc_n       = 0;

  always @(negedge clk) begin
    if (pselx && penable) begin
      if (acc_n >= slv_delay) begin
        pready  = 1'b1;
        prdata  = slv_fixed ? slv_rdata : {12'hA5A, paddr};
        pslverr = slv_err;
      end else begin
        pready  = 1'b0;
        prdata  = 32'hBAD0_0BAD;
        pslverr = slv_err_low;
      end
      acc_n++;
    end else begin
      acc_n   = 0;
      pready  = 1'b0;
      prdata  = 32'hBAD0_0BAD;
      pslverr = slv_err_low;
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;

  mreq_t         mq[$];       // accepted, not yet issued
  mreq_t         m_cur;       // request currently / last on the bus
  int            m_phase = 0; // 0 no transfer, 1 address phase, 2 data phase, 3 response pending
  int            m_low   = 0; // data-phase cycles seen with pready low
  logic [DW-1:0] m_rdata = '0;
  logic          m_err   = 1'b0;
  bit            m_live  = 0;
  int            n_rsp   = 0;

  always @(posedge clk) begin
    bit    s_push;
    mreq_t s_req;
    if (rst) begin
      mq.delete();
      m_phase     = 0;
      m_low       = 0;
      m_cur.write = 1'b0;
      m_cur.addr  = '0;
      m_cur.wdata = '0;
      m_rdata     = '0;
      m_err       = 1'b0;
      m_live      = 1;
    end else if (m_live) begin
      s_push      = req_valid && (mq.size() < DEPTH);
      s_req.write = req_write;
      s_req.addr  = req_addr;
      s_req.wdata = req_wdata;
      case (m_phase)
        0: if (mq.size() > 0) begin
             m_cur   = mq.pop_front();
             m_phase = 1;
           end
        1: begin
             m_phase = 2;
             m_low   = 0;
           end
        2: if (pready) begin
             m_rdata = m_cur.write ? '0 : prdata;
             m_err   = pslverr;
             m_phase = 3;
           end else begin
             m_low++;
             if (m_low == TMO) begin
               m_rdata = '0;
               m_err   = 1'b1;
               m_phase = 3;
             end
           end
        3: if (rsp_ready) begin
             $display("response %0d: addr=0x%05h write=%0b rdata=0x%08h error=%0b",
                      n_rsp, m_cur.addr, m_cur.write, rsp_rdata, rsp_error);
             n_rsp++;
             m_phase = 0;
           end
        default: m_phase = 0;
      endcase
      if (s_push) mq.push_back(s_req);
    end
    #1;
    if (m_live) begin
      check("m_req_ready", 64'(req_ready), 64'(rst ? 1'b0 : (mq.size() < DEPTH)));
      check("m_pselx",     64'(pselx),     64'(m_phase == 1 || m_phase == 2));
      check("m_penable",   64'(penable),   64'(m_phase == 2));
      check("m_paddr",     64'(paddr),     64'(m_cur.addr));
      check("m_pwrite",    64'(pwrite),    64'(m_cur.write));
      check("m_pwdata",    64'(pwdata),    64'(m_cur.wdata));
      check("m_rsp_valid", 64'(rsp_valid), 64'(m_phase == 3));
      if (m_phase == 3) begin
        check("m_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        check("m_rsp_error", 64'(rsp_error), 64'(m_err));
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("push_timeout", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rsp_timeout", 64'(rsp_valid), 64'(1));
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            g;
    int            got;
    logic [AW-1:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_pselx",     64'(pselx),     64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_paddr",     64'(paddr),     64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rel_req_ready", 64'(req_ready), 64'(1));

    // Zero-wait write
    slv_delay = 0; slv_fixed = 1; slv_rdata = 32'h0;
    push(1'b1, 20'h00010, 32'hDEADBEEF);
    check("w_idle_pselx", 64'(pselx), 64'(0));
    @(negedge clk);
    check("w_setup_pselx",   64'(pselx),   64'(1));
    check("w_setup_penable", 64'(penable), 64'(0));
    check("w_setup_paddr",   64'(paddr),   64'(20'h00010));
    @(negedge clk);
    check("w_access_penable", 64'(penable), 64'(1));
    check("w_access_paddr",   64'(paddr),   64'(20'h00010));
    check("w_access_pwdata",  64'(pwdata),  64'(32'hDEADBEEF));
    check("w_access_pwrite",  64'(pwrite),  64'(1));
    @(negedge clk);
    check("w_rsp_valid", 64'(rsp_valid), 64'(1));
    check("w_rsp_error", 64'(rsp_error), 64'(0));
    check("w_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("w_rsp_pselx", 64'(pselx),     64'(0));
    accept();
    check("w_rsp_done", 64'(rsp_valid), 64'(0));

    // Read with three wait states
    slv_delay = 3; slv_rdata = 32'h12345678;
    push(1'b0, 20'h00024, 32'h0);
    wait_rsp(n);
    check("r_latency",   64'(n),         64'(6));
    check("r_rsp_rdata", 64'(rsp_rdata), 64'(32'h12345678));
    check("r_rsp_error", 64'(rsp_error), 64'(0));
    accept();

    // pslverr honoured with pready=1
    slv_delay = 0; slv_err = 1; slv_rdata = 32'hCAFE0001;
    push(1'b0, 20'h00030, 32'h0);
    wait_rsp(n);
    check("e_rsp_error", 64'(rsp_error), 64'(1));
    check("e_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE0001));
    accept();
    // pslverr ignored while pready=0
    slv_delay = 2; slv_err = 0; slv_err_low = 1; slv_rdata = 32'hCAFE0002;
    push(1'b0, 20'h00034, 32'h0);
    wait_rsp(n);
    check("e_low_rsp_error", 64'(rsp_error), 64'(0));
    check("e_low_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE0002));
    accept();
    slv_err_low = 0;

    // Back-to-back requests while a response is held
    slv_delay = 0; slv_fixed = 0;
    push(1'b0, 20'h00100, 32'h0);
    wait_rsp(n);
    for (int i = 0; i < 4; i++) begin
      check("b_ready_before_push", 64'(req_ready), 64'(1));
      a = 20'h00200 + 20'(4 * i);
      push(1'b0, a, 32'h0);
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00210; req_wdata = '0;
    check("b_full_refuse", 64'(req_ready), 64'(0));
    repeat (2) @(negedge clk);
    check("b_full_still", 64'(req_ready), 64'(0));
    check("b_held_rdata", 64'(rsp_rdata), 64'({12'hA5A, 20'h00100}));
    accept();
    check("b_full_before_pop", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("b_ready_after_pop", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    got = 0; g = 0;
    while (got < 5 && g < 200) begin
      if (rsp_valid) begin
        a = 20'h00200 + 20'(4 * got);
        check("b_order_rdata", 64'(rsp_rdata), 64'({12'hA5A, a}));
        got++;
      end
      @(negedge clk);
      g++;
    end
    rsp_ready = 1'b0;
    check("b_rsp_count", 64'(got), 64'(5));

    // Timeout with pready stuck low
    slv_delay = 1000;
    push(1'b0, 20'h00040, 32'h0);
    n = 0; g = 0;
    while (!rsp_valid && g < 100) begin
      if (penable) n++;
      @(negedge clk);
      g++;
    end
    check("t_access_cycles", 64'(n),         64'(8));
    check("t_rsp_valid",     64'(rsp_valid), 64'(1));
    check("t_rsp_error",     64'(rsp_error), 64'(1));
    check("t_rsp_rdata",     64'(rsp_rdata), 64'(0));
    check("t_pselx",         64'(pselx),     64'(0));
    accept();

    // Reset in the middle of ACCESS with two requests queued
    push(1'b1, 20'h00050, 32'h11111111);
    push(1'b1, 20'h00054, 32'h22222222);
    push(1'b1, 20'h00058, 32'h33333333);
    g = 0;
    while (!penable && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("x_in_access", 64'(penable), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("x_pselx",     64'(pselx),     64'(0));
    check("x_penable",   64'(penable),   64'(0));
    check("x_rsp_valid", 64'(rsp_valid), 64'(0));
    check("x_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    slv_delay = 0;
    @(negedge clk);
    check("x_ready_after", 64'(req_ready), 64'(1));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (pselx || rsp_valid) n++;
      @(negedge clk);
    end
    check("x_no_activity", 64'(n), 64'(0));
    slv_fixed = 1; slv_rdata = 32'h0BADF00D;
    push(1'b0, 20'h00060, 32'h0);
    wait_rsp(n);
    check("x_fresh_latency", 64'(n),         64'(3));
    check("x_fresh_rdata",   64'(rsp_rdata), 64'(32'h0BADF00D));
    accept();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
